// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types, constants and sizing helper for the binary-to-BCD converter
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int BCD_W = 4;

   // Decimal digits needed for the largest magnitude a bin_w-bit input can carry.
   function automatic int digits_needed(input int bin_w, input bit signed_flag);
      longint unsigned v;
      int d;
      v = signed_flag ? (64'd1 << (bin_w - 1)) : ((64'd1 << bin_w) - 64'd1);
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - input/output handshake bundle of the binary-to-BCD converter
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   localparam int NDW = $clog2(DIGITS + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic [NDW-1:0]        ndigits;
   logic                  neg;

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd, ndigits, neg
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd, ndigits, neg
   );
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit_i,
   output logic [BCD_W-1:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle shift-and-add-3 binary-to-BCD converter; BIN2BCD_SIGNED_EN enables two's complement input
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter int CNT_W  = $clog2(BIN_W + 1)
) (
   input logic          clk,
   input logic          rst,
   bin2bcd_seq_if.slave bus
);

   localparam int NDW = $clog2(DIGITS + 1);
   localparam int SW  = DIGITS * BCD_W;

`ifdef BIN2BCD_SIGNED_EN
   localparam bit SIGNED_F = 1'b1;
`else
   localparam bit SIGNED_F = 1'b0;
`endif

   generate
      if (BIN_W < 4 || BIN_W > 32) begin : g_width_chk
         $error("bin2bcd_seq: BIN_W must be within 4..32");
      end
      if (digits_needed(BIN_W, SIGNED_F) > DIGITS) begin : g_digits_chk
         $error("bin2bcd_seq: DIGITS too small for BIN_W");
      end
   endgenerate

   state_e           state_q;
   logic [BIN_W-1:0] shreg_q;
   logic [SW-1:0]    scr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SW-1:0]    bcd_q;
   logic [NDW-1:0]   nd_q;

   logic [SW-1:0]    scr_adj;
   logic [SW-1:0]    scr_shift;
   logic [NDW-1:0]   nd_d;
   logic [BIN_W-1:0] load_d;
   logic             last_shift;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scr_q[g*BCD_W +: BCD_W]),
         .digit_o (scr_adj[g*BCD_W +: BCD_W])
      );
   end

   // Adjust first, then shift the binary MSB into the bottom of the digit chain.
   assign scr_shift  = {scr_adj[SW-2:0], shreg_q[BIN_W-1]};
   assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

   always_comb begin
      nd_d = NDW'(1);
      for (int k = 0; k < DIGITS; k++) begin
         if (scr_shift[k*BCD_W +: BCD_W] != 4'd0) begin
            nd_d = NDW'(k + 1);
         end
      end
   end

`ifdef BIN2BCD_SIGNED_EN
   logic neg_d;
   logic sign_q;
   logic neg_q;

   // The most negative input wraps to itself, which is exactly its unsigned magnitude.
   assign load_d = bus.bin[BIN_W-1] ? (~bus.bin + BIN_W'(1)) : bus.bin;
   assign neg_d  = bus.bin[BIN_W-1] && (load_d != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if ((state_q == IDLE) && bus.in_valid) begin
         sign_q <= neg_d;
      end else if (last_shift) begin
         neg_q  <= sign_q;
      end
   end

   assign bus.neg = neg_q;
`else
   assign load_d  = bus.bin;
   assign bus.neg = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         nd_q    <= NDW'(1);
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg_q <= load_d;
                  scr_q   <= '0;
                  cnt_q   <= CNT_W'(BIN_W);
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               scr_q   <= scr_shift;
               shreg_q <= {shreg_q[BIN_W-2:0], 1'b0};
               cnt_q   <= cnt_q - CNT_W'(1);
               if (last_shift) begin
                  bcd_q   <= scr_shift;
                  nd_q    <= nd_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.bcd       = bcd_q;
   assign bus.ndigits   = nd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (16-bit/5-digit and 4-bit/2-digit builds)
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus16 ();
   bin2bcd_seq_if #(.BIN_W(4),  .DIGITS(2)) bus4 ();

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16.slave)
   );

   bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ov(input bit wide);
      return wide ? bus16.out_valid : bus4.out_valid;
   endfunction

   function automatic logic [31:0] bcd_of(input bit wide);
      return wide ? {12'd0, bus16.bcd} : {24'd0, bus4.bcd};
   endfunction

   // Accept one value, measure edges until out_valid, check the result; optionally
   // check the return to IDLE one edge later (out_ready must then be 1).
   task automatic conv(input bit wide, input logic [15:0] val, input logic [19:0] eb,
                       input int en, input logic eneg, input string tag, input bit drain);
      int cyc;
      int lat;
      lat = wide ? 16 : 4;
      if (wide) begin
         bus16.bin      = val;
         bus16.in_valid = 1'b1;
      end else begin
         bus4.bin      = val[3:0];
         bus4.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      bus4.in_valid  = 1'b0;
      cyc = 0;
      while (!ov(wide) && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "/latency"}, cyc, lat);
      check({tag, "/bcd"}, bcd_of(wide), {12'd0, eb});
      check({tag, "/ndigits"}, wide ? 32'(bus16.ndigits) : 32'(bus4.ndigits), en);
      check({tag, "/neg"}, wide ? 32'(bus16.neg) : 32'(bus4.neg), 32'(eneg));
      check({tag, "/busy_in_ready"}, wide ? 32'(bus16.in_ready) : 32'(bus4.in_ready), 0);
      if (drain) begin
         @(posedge clk); #1;
         check({tag, "/idle_in_ready"}, wide ? 32'(bus16.in_ready) : 32'(bus4.in_ready), 1);
         check({tag, "/idle_out_valid"}, 32'(ov(wide)), 0);
         check({tag, "/held_bcd"}, bcd_of(wide), {12'd0, eb});
      end
   endtask

   initial begin
      bit saw;
      logic [19:0] e;
      int nd;
      int top;

      bus16.in_valid  = 1'b0;
      bus16.bin       = '0;
      bus16.out_ready = 1'b1;
      bus4.in_valid   = 1'b0;
      bus4.bin        = '0;
      bus4.out_ready  = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst/out_valid", 32'(bus16.out_valid), 0);
      check("rst/in_ready", 32'(bus16.in_ready), 1);
      check("rst/bcd", 32'(bus16.bcd), 0);
      check("rst/ndigits", 32'(bus16.ndigits), 1);
      check("rst/neg", 32'(bus16.neg), 0);
      check("rst4/ndigits", 32'(bus4.ndigits), 1);
      rst = 1'b1;
      @(posedge clk); #1;

      // Zero input, then width maximum and typical values
      conv(1'b1, 16'd0, 20'h00000, 1, 1'b0, "t1_zero", 1'b1);
`ifndef BIN2BCD_SIGNED_EN
      conv(1'b1, 16'd65535, 20'h65535, 5, 1'b0, "t2_max", 1'b1);
`endif
      conv(1'b1, 16'd1234, 20'h01234, 4, 1'b0, "t2_1234", 1'b1);
      conv(1'b1, 16'd10, 20'h00010, 2, 1'b0, "t2_10", 1'b1);
      conv(1'b1, 16'd9, 20'h00009, 1, 1'b0, "t2_9", 1'b1);

      // Backpressure with ignored in_valid pulses while in DONE
      bus16.out_ready = 1'b0;
      conv(1'b1, 16'd909, 20'h00909, 3, 1'b0, "t3_909", 1'b0);
      for (int i = 0; i < 7; i++) begin
         bus16.in_valid = 1'b1;
         bus16.bin      = 16'd1;
         @(posedge clk); #1;
         check($sformatf("t3_hold%0d/out_valid", i), 32'(bus16.out_valid), 1);
         check($sformatf("t3_hold%0d/in_ready", i), 32'(bus16.in_ready), 0);
         check($sformatf("t3_hold%0d/bcd", i), 32'(bus16.bcd), 32'h00909);
      end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_release/in_ready", 32'(bus16.in_ready), 1);
      check("t3_release/out_valid", 32'(bus16.out_valid), 0);
      @(posedge clk); #1;
      check("t3_not_queued/in_ready", 32'(bus16.in_ready), 1);
      check("t3_not_queued/bcd", 32'(bus16.bcd), 32'h00909);

      // Reset in the middle of a conversion
      bus16.bin      = 16'd4321;
      bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("t4_abort/bcd", 32'(bus16.bcd), 0);
      check("t4_abort/ndigits", 32'(bus16.ndigits), 1);
      check("t4_abort/out_valid", 32'(bus16.out_valid), 0);
      check("t4_abort/in_ready", 32'(bus16.in_ready), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         if (bus16.out_valid) saw = 1'b1;
      end
      check("t4_no_pulse", 32'(saw), 0);
      conv(1'b1, 16'd4321, 20'h04321, 4, 1'b0, "t4_redo", 1'b1);

      // Narrow build sweep
`ifdef BIN2BCD_SIGNED_EN
      top = 7;
`else
      top = 15;
`endif
      for (int v = 0; v <= top; v++) begin
         e  = {12'd0, 4'(v / 10), 4'(v % 10)};
         nd = (v >= 10) ? 2 : 1;
         conv(1'b0, 16'(v), e, nd, 1'b0, $sformatf("t5_%0d", v), 1'b1);
      end

`ifdef BIN2BCD_SIGNED_EN
      conv(1'b1, 16'h8000, 20'h32768, 5, 1'b1, "t6_min", 1'b1);
      conv(1'b1, 16'hFFFF, 20'h00001, 1, 1'b1, "t6_m1", 1'b1);
      conv(1'b1, 16'h0000, 20'h00000, 1, 1'b0, "t6_zero", 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Replaces the fixed 4-bit lookup converter for wider display and readout paths, such as counters and ADC values feeding the 7-segment scanner.
- Uses a valid/ready handshake on both the input and the output side.
- Also reports how many digits are significant, so downstream logic can blank leading zeros.

Parameters:
- BIN_W, 16, binary input width; legal range 4..32.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W - 1. An elaboration-time check fails the build otherwise.
- CNT_W, $clog2(BIN_W+1), derived width of the bit counter; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  `bin` is valid.
- in_ready  out  1  converter can accept a new value.
- bin  in  BIN_W  binary value; sampled only on the in_valid && in_ready edge.
- out_valid  out  1  `bcd`, `ndigits` and `neg` hold a completed result.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  packed BCD; digit 0 is in [3:0] and is the least significant.
- ndigits  out  $clog2(DIGITS+1)  count of significant digits; the value 0 reports 1.
- neg  out  1  sign flag; tied 0 unless BIN2BCD_SIGNED_EN is defined.

Behaviour:
- Reset is clk, rst: asynchronous, active-low. While rst=0:
  - state=IDLE; shift register, scratch BCD and counter are cleared.
  - bcd=0, ndigits=1, neg=0, out_valid=0, in_ready=1.
- FSM states are IDLE, SHIFT and DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state with no combinational path from the inputs.
- IDLE:
  - On in_valid=1, capture `bin` into the shift register, clear the scratch digits, load counter=BIN_W, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, shreg} is shifted left by 1.
  - Then counter is decremented.
  - When counter==1 at the start of the cycle (the last shift), the shifted scratch is written to `bcd`, `ndigits` and `neg` register, and the FSM goes to DONE.
- Latency: if the input is accepted at edge T, out_valid rises at edge T+BIN_W. Throughput is at most one result per BIN_W+2 cycles when out_ready is held at 1.
- DONE:
  - bcd, ndigits and neg hold stable while out_ready=0 (backpressure of any length).
  - On out_ready=1, go to IDLE; out_valid falls and in_ready rises on the same edge.
  - A new input is not accepted in the DONE cycle.
- Output registers keep the last result after leaving DONE. They change only at the next completion or at reset.
- ndigits = index of the highest nonzero digit + 1, or 1 if every digit is 0.
- A digit never exceeds 9 after the adjust step. Unused upper digits stay 0.
- in_valid while busy is ignored and not queued. `bin` changing mid-conversion has no effect.
- Reset asserted mid-conversion aborts immediately. No out_valid pulse is produced for the aborted value.

Optional Feature:
BIN2BCD_SIGNED_EN
- Defined:
  - `bin` is two's complement.
  - On capture, the shift register loads |bin|; -2^(BIN_W-1) is handled as unsigned magnitude 2^(BIN_W-1).
  - `neg` is set when bin[BIN_W-1]=1 and the magnitude is nonzero.
  - The DIGITS check uses 2^(BIN_W-1).
- Undefined:
  - `bin` is unsigned and neg=0 constantly.
  - No negation logic is generated.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - the state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the BCD digit width constant 4;
  - the function digits_needed(bin_w, signed_flag) used by the elaboration check.
- One sub-module, bcd_digit_adj:
  - a combinational 4-bit stage, out = (in>=5) ? in+3 : in;
  - instantiated DIGITS times with a generate loop.
- The FSM, counter and output registers stay in bin2bcd_seq.

Test Plan:
1. BIN_W=16, DIGITS=5, bin=0, out_ready=1 -> out_valid exactly 16 cycles after acceptance, bcd=20'h00000, ndigits=1, then in_ready=1.
2. bin=65535 -> bcd=20'h65535, ndigits=5; then bin=1234 -> bcd=20'h01234, ndigits=4.
3. bin=909 with out_ready=0 for 7 cycles -> bcd=20'h00909 stable, in_ready=0 and extra in_valid pulses ignored; out_ready=1 -> IDLE next edge.
4. Drop rst at cycle 8 of a conversion of 4321 -> outputs 0, ndigits=1, no out_valid; after release, 4321 -> 20'h04321.
5. BIN_W=4, DIGITS=2, sweep 0..15 -> bcd equals {tens,units}, e.g. 15 -> 8'h15, 10 -> 8'h10, out_valid 4 cycles after each acceptance.
6. With BIN2BCD_SIGNED_EN and BIN_W=16 -> bin=16'h8000 gives neg=1, bcd=20'h32768; bin=-1 gives neg=1, bcd=20'h00001; bin=0 gives neg=0.
